// File: rtl/beam_trigger_processor.sv
// Masks per-beam triggers, applies holdoff, and timestamps accepted events into a 1-entry valid/ready register.
// Latency: trig_i sampled at edge k is loaded at edge k+1 and seen as valid at edge k+2.
// Backpressure: an accept while the output is full and not being taken is dropped and counted.
module beam_trigger_processor #(
    parameter int NBEAMS       = 2,
    parameter int HOLDOFF_BITS = 8,
    parameter int TSTAMP_BITS  = 16,
    parameter int DROP_BITS    = 16
) (
    input  logic                    ifclk,
    input  logic                    ifclk_rst_i,
    input  logic [NBEAMS-1:0]       trig_i,
    input  logic [NBEAMS-1:0]       mask_i,
    input  logic                    enable_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    drop_clr_i,
    output logic                    evt_valid_o,
    input  logic                    evt_ready_i,
    output logic [NBEAMS-1:0]       evt_beams_o,
    output logic [TSTAMP_BITS-1:0]  evt_time_o,
    output logic                    busy_o,
    output logic [DROP_BITS-1:0]    drop_count_o
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_HOLDOFF = 1'b1;

    logic [0:0]              state;
    logic [HOLDOFF_BITS-1:0] hoc;
    logic [TSTAMP_BITS-1:0]  tstamp;
    logic [NBEAMS-1:0]       hit_q;
    logic [TSTAMP_BITS-1:0]  time_q;
    logic                    accept;
    logic                    take;
    logic                    drop;

    assign accept = (state == S_IDLE) && (|hit_q);
    assign take   = accept && (!evt_valid_o || evt_ready_i);
    assign drop   = accept && !take;
    assign busy_o = (state == S_HOLDOFF);

    always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
        if (ifclk_rst_i) begin
            tstamp <= '0;
            hit_q  <= '0;
            time_q <= '0;
        end else begin
            tstamp <= tstamp + 1'b1;
            hit_q  <= trig_i & ~mask_i & {NBEAMS{enable_i}};
            time_q <= tstamp;
        end
    end

    // holdoff is latched only at acceptance, so later changes wait for the next event
    always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
        if (ifclk_rst_i) begin
            state <= S_IDLE;
            hoc   <= '0;
        end else if (state == S_IDLE) begin
            if (accept) begin
                hoc <= holdoff_i;
                if (holdoff_i != '0) begin
                    state <= S_HOLDOFF;
                end
            end
        end else begin
            hoc <= hoc - 1'b1;
            if (hoc == HOLDOFF_BITS'(1)) begin
                state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
        if (ifclk_rst_i) begin
            evt_valid_o <= 1'b0;
            evt_beams_o <= '0;
            evt_time_o  <= '0;
        end else if (take) begin
            evt_valid_o <= 1'b1;
            evt_beams_o <= hit_q;
            evt_time_o  <= time_q;
        end else if (evt_valid_o && evt_ready_i) begin
            evt_valid_o <= 1'b0;
        end
    end

    // a clear coinciding with a drop leaves the count at one
    always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
        if (ifclk_rst_i) begin
            drop_count_o <= '0;
        end else if (drop_clr_i) begin
            drop_count_o <= drop ? DROP_BITS'(1) : '0;
        end else if (drop && !(&drop_count_o)) begin
            drop_count_o <= drop_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_beam_trigger_processor.sv
// Directed and randomized checks of beam_trigger_processor against a timing-arithmetic reference model.
module tb_beam_trigger_processor;

    localparam int NB = 2;
    localparam int HB = 8;
    localparam int TB = 16;
    localparam int DB = 8;

    logic          ifclk = 1'b0;
    logic          rst   = 1'b1;
    logic [NB-1:0] trig  = '0;
    logic [NB-1:0] mask  = '0;
    logic          en    = 1'b1;
    logic [HB-1:0] hold  = '0;
    logic          clr   = 1'b0;
    logic          ready = 1'b1;

    logic          evt_valid_o;
    logic [NB-1:0] evt_beams_o;
    logic [TB-1:0] evt_time_o;
    logic          busy_o;
    logic [DB-1:0] drop_count_o;

    beam_trigger_processor #(
        .NBEAMS(NB), .HOLDOFF_BITS(HB), .TSTAMP_BITS(TB), .DROP_BITS(DB)
    ) dut (
        .ifclk        (ifclk),
        .ifclk_rst_i  (rst),
        .trig_i       (trig),
        .mask_i       (mask),
        .enable_i     (en),
        .holdoff_i    (hold),
        .drop_clr_i   (clr),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (ready),
        .evt_beams_o  (evt_beams_o),
        .evt_time_o   (evt_time_o),
        .busy_o       (busy_o),
        .drop_count_o (drop_count_o)
    );

    always #5 ifclk = ~ifclk;

    int tests = 0;
    int fails = 0;

    // Reference model: edge index arithmetic instead of an explicit state machine
    int            e;
    int            next_ok;
    logic          m_valid;
    logic [NB-1:0] m_beams;
    logic [TB-1:0] m_time;
    logic [NB-1:0] m_hit;
    logic [TB-1:0] m_tq;
    logic [TB-1:0] m_ts;
    logic [DB-1:0] m_drop;

    int            valid_cycles;
    int            busy_cycles;
    logic [TB-1:0] evt_times[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        e       = 0;
        next_ok = 0;
        m_valid = 1'b0;
        m_beams = '0;
        m_time  = '0;
        m_hit   = '0;
        m_tq    = '0;
        m_ts    = '0;
        m_drop  = '0;
    endtask

    task automatic model_edge();
        bit hs;
        bit acc;
        e++;
        hs  = m_valid && ready;
        acc = (m_hit != '0) && (e >= next_ok);
        if (clr) m_drop = '0;
        if (acc) begin
            next_ok = e + int'(hold) + 1;
            if (!m_valid || hs) begin
                m_valid = 1'b1;
                m_beams = m_hit;
                m_time  = m_tq;
            end else if (m_drop != {DB{1'b1}}) begin
                m_drop = m_drop + 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
        m_hit = trig & ~mask & {NB{en}};
        m_tq  = m_ts;
        m_ts  = m_ts + 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(evt_valid_o), 32'(m_valid));
        chk({tag, "_beams"}, 32'(evt_beams_o), 32'(m_beams));
        chk({tag, "_time"},  32'(evt_time_o),  32'(m_time));
        chk({tag, "_busy"},  32'(busy_o),      32'(e < next_ok - 1));
        chk({tag, "_drop"},  32'(drop_count_o), 32'(m_drop));
    endtask

    task automatic cyc(input string tag);
        @(posedge ifclk);
        model_edge();
        #1;
        check_all(tag);
        if (evt_valid_o) begin
            valid_cycles++;
            evt_times.push_back(evt_time_o);
        end
        if (busy_o) busy_cycles++;
    endtask

    task automatic clear_stats();
        valid_cycles = 0;
        busy_cycles  = 0;
        evt_times.delete();
    endtask

    task automatic do_reset();
        @(negedge ifclk);
        rst = 1'b1;
        trig = '0; mask = '0; en = 1'b1; hold = '0; clr = 1'b0; ready = 1'b1;
        model_reset();
        @(negedge ifclk);
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_stats();

        // 1: single event at tstamp 5 with holdoff 3
        do_reset();
        hold = 8'd3;
        repeat (5) cyc("t1");
        clear_stats();
        trig = 2'b01;
        cyc("t1");
        trig = 2'b00;
        repeat (8) cyc("t1");
        chk("t1_valid_cycles", 32'(valid_cycles), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd3);
        chk("t1_evt_time", 32'(evt_times.size() > 0 ? evt_times[0] : 16'hFFFF), 32'd5);

        // 2: trigger held 6 cycles under holdoff 3 yields events at 10 and 14
        do_reset();
        hold = 8'd3;
        repeat (10) cyc("t2");
        clear_stats();
        trig = 2'b11;
        repeat (6) cyc("t2");
        trig = 2'b00;
        repeat (6) cyc("t2");
        chk("t2_events", 32'(valid_cycles), 32'd2);
        chk("t2_time0", 32'(evt_times.size() > 0 ? evt_times[0] : 16'hFFFF), 32'd10);
        chk("t2_time1", 32'(evt_times.size() > 1 ? evt_times[1] : 16'hFFFF), 32'd14);
        chk("t2_drop", 32'(drop_count_o), 32'd0);

        // 3: masked beam, then disabled
        clear_stats();
        mask = 2'b10;
        trig = 2'b10;
        cyc("t3m");
        trig = 2'b00;
        repeat (4) cyc("t3m");
        mask = 2'b00;
        en   = 1'b0;
        trig = 2'b10;
        cyc("t3e");
        trig = 2'b00;
        repeat (4) cyc("t3e");
        en = 1'b1;
        chk("t3_events", 32'(valid_cycles), 32'd0);
        chk("t3_busy", 32'(busy_cycles), 32'd0);

        // 4: output stalled, later events dropped
        do_reset();
        hold  = 8'd0;
        ready = 1'b0;
        repeat (2) cyc("t4");
        for (int i = 0; i < 3; i++) begin
            trig = (i == 0) ? 2'b01 : 2'b10;
            cyc("t4");
            trig = 2'b00;
            repeat (2) cyc("t4");
        end
        chk("t4_drop", 32'(drop_count_o), 32'd2);
        chk("t4_held_beams", 32'(evt_beams_o), 32'd1);
        ready = 1'b1;
        cyc("t4");
        chk("t4_valid_after_ready", 32'(evt_valid_o), 32'd0);

        // 5: handshake and accept on the same edge
        do_reset();
        hold  = 8'd0;
        ready = 1'b1;
        repeat (3) cyc("t5");
        trig = 2'b10;
        cyc("t5");
        trig = 2'b01;
        cyc("t5");
        trig = 2'b00;
        cyc("t5");
        chk("t5_valid_kept", 32'(evt_valid_o), 32'd1);
        chk("t5_second_beams", 32'(evt_beams_o), 32'd1);
        cyc("t5");
        chk("t5_drop", 32'(drop_count_o), 32'd0);

        // 6a: asynchronous reset mid-holdoff with a pending event
        do_reset();
        hold  = 8'd10;
        ready = 1'b0;
        repeat (4) cyc("t6a");
        trig = 2'b11;
        cyc("t6a");
        trig = 2'b00;
        repeat (3) cyc("t6a");
        #2;
        rst = 1'b1;
        #1;
        chk("t6a_valid", 32'(evt_valid_o), 32'd0);
        chk("t6a_beams", 32'(evt_beams_o), 32'd0);
        chk("t6a_time", 32'(evt_time_o), 32'd0);
        chk("t6a_busy", 32'(busy_o), 32'd0);
        model_reset();
        hold  = 8'd0;
        ready = 1'b1;
        @(negedge ifclk);
        rst = 1'b0;
        repeat (3) cyc("t6a_post");

        // 6b: drop counter saturation, clear, and clear-with-drop
        do_reset();
        hold  = 8'd0;
        ready = 1'b0;
        trig  = 2'b11;
        repeat (262) cyc("t6b");
        chk("t6b_sat", 32'(drop_count_o), 32'hFF);
        trig = 2'b00;
        repeat (2) cyc("t6b");
        clr = 1'b1;
        cyc("t6b");
        clr = 1'b0;
        chk("t6b_clr", 32'(drop_count_o), 32'd0);
        trig = 2'b01;
        repeat (3) cyc("t6b");
        clr = 1'b1;
        cyc("t6b");
        clr = 1'b0;
        chk("t6b_clr_and_drop", 32'(drop_count_o), 32'd1);
        trig = 2'b00;
        repeat (2) cyc("t6b");

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            trig  = NB'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
            en    = ($urandom_range(0, 7) != 0);
            hold  = HB'($urandom_range(0, 4));
            ready = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 15) == 0);
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
